// File: rtl/connect4_board_engine_pkg.sv
// Shared Connect 4 types: board geometry, cell encoding and engine state encoding.
package connect4_tipos;

  localparam int ROWS    = 6;
  localparam int COLS    = 7;
  localparam int WIN_LEN = 4;
  localparam int CELLS   = ROWS * COLS;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    J1    = 2'b01,
    J2    = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PLACE  = 3'd1,
    CHK_H  = 3'd2,
    CHK_V  = 3'd3,
    CHK_D1 = 3'd4,
    CHK_D2 = 3'd5,
    DONE   = 3'd6
  } state_t;

  function automatic cell_t player_cell(input logic player);
    return player ? J2 : J1;
  endfunction

endpackage

// File: rtl/connect4_board_engine_if.sv
// Move request / result bundle between the game-control FSM (master) and the board engine (slave).
interface connect4_board_engine_if;
  import connect4_tipos::*;

  logic                      clear;
  logic                      move_req;
  logic                      move_player;
  logic [2:0]                move_col;
  logic                      busy;
  logic                      move_done;
  logic                      move_valid;
  logic                      is_winner;
  logic                      is_draw;
  logic [ROWS-1:0][COLS-1:0] board_j1;
  logic [ROWS-1:0][COLS-1:0] board_j2;

  modport master (
    output clear, move_req, move_player, move_col,
    input  busy, move_done, move_valid, is_winner, is_draw, board_j1, board_j2
  );

  modport slave (
    input  clear, move_req, move_player, move_col,
    output busy, move_done, move_valid, is_winner, is_draw, board_j1, board_j2
  );

endinterface

// File: rtl/connect4_run_counter.sv
// Combinational run length through (row, col) along +/-(dr, dc), saturating at WIN_LEN.
module connect4_run_counter
  import connect4_tipos::*;
(
  input  cell_t             i_cells [ROWS][COLS],
  input  logic [2:0]        i_row,
  input  logic [2:0]        i_col,
  input  logic              i_player,
  input  logic signed [1:0] i_dr,
  input  logic signed [1:0] i_dc,
  output logic [2:0]        o_run_len
);

  cell_t w_me;
  int    w_total;
  int    w_step;
  int    w_rr;
  int    w_cc;
  logic  w_alive;

  assign w_me = player_cell(i_player);

  // Each side walks outward until it leaves the board or hits a foreign cell.
  always_comb begin
    w_total = 1;
    w_step  = 0;
    w_rr    = 0;
    w_cc    = 0;
    w_alive = 1'b1;
    for (int side = 0; side < 2; side++) begin
      w_alive = 1'b1;
      for (int k = 1; k < WIN_LEN; k++) begin
        w_step = (side == 0) ? k : -k;
        w_rr   = int'(i_row) + w_step * int'(i_dr);
        w_cc   = int'(i_col) + w_step * int'(i_dc);
        if (w_alive && (w_rr >= 0) && (w_rr < ROWS) && (w_cc >= 0) && (w_cc < COLS)
            && (i_cells[3'(w_rr)][3'(w_cc)] == w_me)) begin
          w_total = w_total + 1;
        end else begin
          w_alive = 1'b0;
        end
      end
    end
    o_run_len = (w_total >= WIN_LEN) ? 3'(WIN_LEN) : 3'(w_total);
  end

endmodule

// File: rtl/connect4_board_engine.sv
// Connect 4 board store and rules engine: drops a piece, scans four axes for a win, reports draw.
module connect4_board_engine
  import connect4_tipos::*;
(
  input  logic                    clk,
  input  logic                    rst,
  connect4_board_engine_if.slave  bus
);

  state_t     r_state;
  cell_t      r_cells [ROWS][COLS];
  logic [2:0] r_height [COLS];
  logic [5:0] r_count;
  logic       r_game_over;
  logic       r_player;
  logic [2:0] r_col;
  logic [2:0] r_row;
  logic       r_win;
  logic       r_busy;
  logic       r_done;
  logic       r_valid;
  logic       r_winner;
  logic       r_draw;

  logic [2:0]                w_cur_height;
  logic                      w_move_ok;
  logic                      w_full;
  logic                      w_hit;
  logic                      w_win_final;
  logic signed [1:0]         w_dr;
  logic signed [1:0]         w_dc;
  logic [2:0]                w_run_len;
  cell_t                     w_player_cell;
  logic [ROWS-1:0][COLS-1:0] w_board_j1;
  logic [ROWS-1:0][COLS-1:0] w_board_j2;

  always_comb begin
    w_cur_height = '0;
    if (r_col < 3'(COLS)) w_cur_height = r_height[r_col];
  end

  assign w_move_ok     = (r_col < 3'(COLS)) && (w_cur_height != 3'(ROWS)) && !r_game_over;
  assign w_full        = (r_count == 6'(CELLS));
  assign w_player_cell = player_cell(r_player);
  assign w_hit         = (w_run_len >= 3'(WIN_LEN));
  assign w_win_final   = r_win | w_hit;

  // D1 is the / diagonal, D2 the \ diagonal.
  always_comb begin
    w_dr = 2'sd0;
    w_dc = 2'sd1;
    case (r_state)
      CHK_V:   begin w_dr = 2'sd1; w_dc = 2'sd0;  end
      CHK_D1:  begin w_dr = 2'sd1; w_dc = 2'sd1;  end
      CHK_D2:  begin w_dr = 2'sd1; w_dc = -2'sd1; end
      default: begin w_dr = 2'sd0; w_dc = 2'sd1;  end
    endcase
  end

  connect4_run_counter u_run_counter (
    .i_cells   (r_cells),
    .i_row     (r_row),
    .i_col     (r_col),
    .i_player  (r_player),
    .i_dr      (w_dr),
    .i_dc      (w_dc),
    .o_run_len (w_run_len)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_game_over <= 1'b0;
      r_player    <= 1'b0;
      r_col       <= '0;
      r_row       <= '0;
      r_win       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_valid     <= 1'b0;
      r_winner    <= 1'b0;
      r_draw      <= 1'b0;
      for (int j = 0; j < COLS; j++) r_height[j] <= '0;
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) r_cells[i][j] <= EMPTY;
    end else if (bus.clear) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_game_over <= 1'b0;
      r_win       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_valid     <= 1'b0;
      r_winner    <= 1'b0;
      r_draw      <= 1'b0;
      for (int j = 0; j < COLS; j++) r_height[j] <= '0;
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) r_cells[i][j] <= EMPTY;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.move_req) begin
            r_player <= bus.move_player;
            r_col    <= bus.move_col;
            r_valid  <= 1'b0;
            r_winner <= 1'b0;
            r_draw   <= 1'b0;
            r_win    <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= PLACE;
          end
        end
        PLACE: begin
          if (w_move_ok) begin
            r_cells[w_cur_height][r_col] <= w_player_cell;
            r_height[r_col]              <= w_cur_height + 3'd1;
            r_count                      <= r_count + 6'd1;
            r_row                        <= w_cur_height;
            r_valid                      <= 1'b1;
            r_state                      <= CHK_H;
          end else begin
            // Rejected moves skip the scan; the win flag is already clear.
            r_valid     <= 1'b0;
            r_draw      <= w_full;
            r_game_over <= r_game_over | w_full;
            r_done      <= 1'b1;
            r_state     <= DONE;
          end
        end
        CHK_H: begin
          r_win   <= w_win_final;
          r_state <= CHK_V;
        end
        CHK_V: begin
          r_win   <= w_win_final;
          r_state <= CHK_D1;
        end
        CHK_D1: begin
          r_win   <= w_win_final;
          r_state <= CHK_D2;
        end
        CHK_D2: begin
          r_win       <= w_win_final;
          r_winner    <= w_win_final;
          r_draw      <= w_full && !w_win_final;
          r_game_over <= r_game_over | w_win_final | w_full;
          r_done      <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      assign w_board_j1[gi][gj] = (r_cells[gi][gj] == J1);
      assign w_board_j2[gi][gj] = (r_cells[gi][gj] == J2);
    end
  end

  assign bus.busy       = r_busy;
  assign bus.move_done  = r_done;
  assign bus.move_valid = r_valid;
  assign bus.is_winner  = r_winner;
  assign bus.is_draw    = r_draw;
  assign bus.board_j1   = w_board_j1;
  assign bus.board_j2   = w_board_j2;

endmodule

// File: doc/connect4_board_engine.md
# connect4_board_engine

Board datapath and rules engine for Connect 4. It receives one move request at a time from the game-control FSM and drops the current player's piece into the requested column. It then runs a four-direction win scan and returns a one-cycle completion pulse together with three results: move validity, winner, and draw. It is the only block that stores the 6×7 board, and it drives the board planes read by the display path.

## Interface
Parameters:
- ROWS, 6, board rows; row 0 is the bottom row.
- COLS, 7, board columns; column 0 is the leftmost column.
- WIN_LEN, 4, run length that wins the game.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- clear  in  1  synchronous new-game clear.
- move_req  in  1  move request, sampled only while busy=0.
- move_player  in  1  player for the move: 0 = J1, 1 = J2.
- move_col  in  3  target column.
- busy  out  1  high whenever the engine is not idle.
- move_done  out  1  one-cycle completion pulse.
- move_valid  out  1  the last move was placed.
- is_winner  out  1  the last move completed a run of WIN_LEN or more.
- is_draw  out  1  the board is full and the last move did not win.
- board_j1  out  ROWS×COLS  packed [ROWS-1:0][COLS-1:0]; bit set = J1 piece in that cell.
- board_j2  out  ROWS×COLS  same layout as board_j1, for J2 pieces.

## Operation
- **Reset (rst high):** every output goes to 0, the board is empty, all column heights are 0, game_over is 0, and the state is IDLE.
- **States:** IDLE, PLACE, CHK_H, CHK_V, CHK_D1 (the / diagonal), CHK_D2 (the \ diagonal), DONE.
- **IDLE:**
  - When move_req=1, latch move_player and move_col, clear the result outputs, and go to PLACE.
  - Hold move_req for one cycle only; if it stays high through DONE it issues a new request on return to IDLE.
- **PLACE:** the move is invalid if any of the following holds:
  - move_col ≥ COLS;
  - the column height equals ROWS;
  - game_over is 1.
- **Invalid move:** set move_valid=0, leave the board unchanged, and go to DONE.
- **Valid move:**
  - Write the piece at (row = height[col], col) and increment height[col].
  - Latch that row as r, the column as c, and the piece count.
  - Set move_valid=1 and go to CHK_H.
- **CHK_x states (one cycle each, in the order H, V, D1, D2):**
  - Count contiguous same-player cells starting from (r,c), in both directions along the axis.
  - Stop each direction at the board edge, at a different cell, or after WIN_LEN−1 steps.
  - If 1 + left count + right count ≥ WIN_LEN, set the win flag.
  - The scan sees the board with the new piece already written.
- **DONE:**
  - move_done=1 for this cycle only.
  - is_winner = win flag.
  - is_draw = (piece count = ROWS×COLS) AND NOT win flag.
  - game_over is set if either is_winner or is_draw is 1.
  - Next state is IDLE.
- **Result outputs:** move_valid, is_winner and is_draw hold from DONE until the next request is accepted.
- **clear:** has priority over everything except rst.
  - In any state: empty the board, zero the heights and piece count, clear game_over and all result outputs, and go to IDLE.
  - An operation in flight is aborted and no move_done is produced.
- **Moves after game over:** with game_over=1, every request completes as invalid until clear.

## Timing
- The request is accepted at clock edge N.
- Valid move:
  - The board planes reflect the new piece after edge N+1.
  - move_done is high during the cycle after edge N+5.
  - busy is high from edge N through the DONE cycle.
- Invalid move: move_done is high during the cycle after edge N+1.
- The next request can be accepted at the first edge after the DONE cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- A column filling up on the same move as a win reports is_winner=1 and is_draw=0.

## Structure
- **Shared package connect4_tipos:**
  - the ROWS, COLS and WIN_LEN constants;
  - the cell encoding type (EMPTY=00, J1=01, J2=10);
  - the engine state enum, 3 bits.
- **Internal storage:** board as cells[ROWS][COLS] of the cell type; height as 3 bits per column; piece count as 6 bits.
- **Sub-module connect4_run_counter:**
  - Purely combinational.
  - Inputs: board, r, c, player, and a direction vector (dr, dc); the direction is selected by state.
  - Output: the run length, saturating at WIN_LEN.

## Test plan
- **Placement stack:** reset, then J1 plays col 3 three times. Expect board_j1[0..2][3]=1, move_valid=1 each time, move_done 5 cycles after each acceptance, is_winner=0.
- **Vertical win:** J1 plays col 0 four times, with J2 plays on col 1 in between. On the fourth J1 move expect is_winner=1. A further J2 move to col 2 returns move_valid=0 and leaves board_j2[0][2]=0.
- **Diagonal wins:**
  - Build a / diagonal for J2 at (0,0), (1,1), (2,2), (3,3), with the final piece dropped at (3,3). Expect is_winner=1.
  - Mirror the test for \ ending at (0,6).
- **Invalid moves:**
  - move_col=7: expect move_done one cycle after acceptance, move_valid=0, board unchanged.
  - Fill col 5 with 6 alternating pieces, then a seventh move: move_valid=0.
- **Draw:** fill all 42 cells in a pattern with no run of 4. On the 42nd move expect is_draw=1 and is_winner=0; the next move is invalid.
- **Clear and reset mid-operation:**
  - Assert clear during CHK_V. Expect no move_done, board_j1=board_j2=0, busy=0 next cycle.
  - Assert rst asynchronously mid-PLACE. All outputs go to 0 immediately.
